// File: rtl/ones_count_pkg.sv
// Shared constants for the ones_count scheduler: FSM state encoding and the
// ceiling-log2 helper used to size the total and requester-id fields.
package ones_count_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ones_count.sv
// Combinational 8-bit population counter; one instance is time-shared by the
// scheduler across all requesters.
module ones_count (
  input  logic [7:0] dat_in,
  output logic [3:0] count
);

  always_comb begin
    count = '0;
    for (int b = 0; b < 8; b++) begin
      count = count + {3'b000, dat_in[b]};
    end
  end

endmodule

// File: rtl/ones_count_sched.sv
// Round-robin scheduler that captures one requester's word, streams it a byte
// per cycle through the shared ones_count, and returns the tagged total.
module ones_count_sched
  import ones_count_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int WORD_BYTES = 4,
  localparam int CW         = clog2(8 * WORD_BYTES + 1),
  localparam int IDW        = (clog2(N_REQ) > 1) ? clog2(N_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ*8*WORD_BYTES-1:0]   dat_in,
  output logic [N_REQ-1:0]                gnt,
  output logic                            busy,
  output logic                            done,
  output logic [IDW-1:0]                  done_id,
  output logic [CW-1:0]                   total
);

  localparam int WW   = 8 * WORD_BYTES;
  localparam int IDXW = (clog2(WORD_BYTES) > 1) ? clog2(WORD_BYTES) : 1;

  logic [0:0]       state_q, state_d;
  logic [WW-1:0]    sh_q, sh_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic [CW-1:0]    total_q, total_d;

  logic [3:0]       byte_cnt;
  logic             found;
  logic [IDW-1:0]   win;

  ones_count u_ones_count (
    .dat_in (sh_q[7:0]),
    .count  (byte_cnt)
  );

  // Priority search starting at ptr_q and wrapping; first asserted req wins.
  always_comb begin
    int c;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      c = int'(ptr_q) + k;
      if (c >= N_REQ) c = c - N_REQ;
      if (!found && req[c]) begin
        found = 1'b1;
        win   = IDW'(c);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    gnt_d     = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    total_d   = total_q;
    if (state_q == ST_IDLE) begin
      busy_d = 1'b0;
      if (found) begin
        sh_d       = dat_in[int'(win)*WW +: WW];
        acc_d      = '0;
        idx_d      = '0;
        gnt_d[win] = 1'b1;
        busy_d     = 1'b1;
        ptr_d      = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
        id_d       = win;
        state_d    = ST_RUN;
      end
    end else begin
      acc_d = acc_q + CW'(byte_cnt);
      sh_d  = sh_q >> 8;
      idx_d = idx_q + 1'b1;
      if (idx_q == IDXW'(WORD_BYTES - 1)) begin
        total_d   = acc_q + CW'(byte_cnt);
        done_id_d = id_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      id_q      <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      total_q   <= '0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      total_q   <= total_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign total   = total_q;

endmodule

// File: tb/tb_ones_count_sched.sv
// Self-checking bench for ones_count_sched: directed table, reset/corner
// sequences, a WORD_BYTES=1 build, and randomized traffic against a model.
module tb_ones_count_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = '0;
  logic [127:0] dat_in = '0;
  logic [3:0]   gnt;
  logic         busy, done;
  logic [1:0]   done_id;
  logic [5:0]   total;

  logic         rst1_n = 1'b0;
  logic [3:0]   req1 = '0;
  logic [31:0]  dat1 = '0;
  logic [3:0]   gnt1;
  logic         busy1, done1;
  logic [1:0]   done_id1;
  logic [3:0]   total1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ones_count_sched #(.N_REQ(4), .WORD_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .dat_in(dat_in),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .total(total)
  );

  ones_count_sched #(.N_REQ(4), .WORD_BYTES(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .req(req1), .dat_in(dat1),
    .gnt(gnt1), .busy(busy1), .done(done1), .done_id(done_id1), .total(total1)
  );

  typedef struct {
    bit           do_rst;
    logic [3:0]   req;
    logic [127:0] dat;
    int           exp_id;
    int           exp_total;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic reset_main();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    check("rst gnt", gnt, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst done_id", done_id, 0);
    check("rst total", total, 0);
    rst_n = 1'b1;
  endtask

  // Called at a negedge where the DUT is idle (or in its done cycle) with req set.
  task automatic serve(input int exp_id, input int exp_total, input string nm);
    logic [3:0] oh;
    oh = 4'b0001 << exp_id;
    @(posedge clk); @(negedge clk);
    check({nm, " gnt"}, gnt, oh);
    check({nm, " busy0"}, busy, 1);
    check({nm, " done0"}, done, 0);
    req[exp_id] = 1'b0;
    dat_in[exp_id*32 +: 32] = $urandom;
    for (int c = 1; c < 4; c++) begin
      @(posedge clk); @(negedge clk);
      check({nm, " gnt_run"}, gnt, 0);
      check({nm, " busy_run"}, busy, 1);
      check({nm, " done_run"}, done, 0);
    end
    @(posedge clk); @(negedge clk);
    check({nm, " done"}, done, 1);
    check({nm, " busy_end"}, busy, 0);
    check({nm, " done_id"}, done_id, exp_id);
    check({nm, " total"}, total, exp_total);
    $display("txn %s: id=%0d total=%0d", nm, done_id, total);
  endtask

  vec_t vecs[8];
  int   mptr;

  initial begin
    vecs[0] = '{1'b1, 4'b0100, {32'h0, 32'hFFFFFFFF, 32'h0, 32'h0}, 2, 32};
    vecs[1] = '{1'b1, 4'b1111, {32'h00000000, 32'h00FF00FF, 32'h00000003, 32'h00000001}, 0, 1};
    vecs[2] = '{1'b0, 4'b1110, {32'h00000000, 32'h00FF00FF, 32'h00000003, 32'h00000001}, 1, 2};
    vecs[3] = '{1'b0, 4'b1100, {32'h00000000, 32'h00FF00FF, 32'h00000003, 32'h00000001}, 2, 16};
    vecs[4] = '{1'b0, 4'b1000, {32'h00000000, 32'h00FF00FF, 32'h00000003, 32'h00000001}, 3, 0};
    vecs[5] = '{1'b0, 4'b1010, {32'h0F0F0F0F, 32'h0, 32'h80000001, 32'h0}, 1, 2};
    vecs[6] = '{1'b0, 4'b1010, {32'h0F0F0F0F, 32'h0, 32'h80000001, 32'h0}, 3, 16};
    vecs[7] = '{1'b0, 4'b0010, {32'h0F0F0F0F, 32'h0, 32'h80000001, 32'h0}, 1, 2};

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_rst) reset_main();
      req    = vecs[i].req;
      dat_in = vecs[i].dat;
      serve(vecs[i].exp_id, vecs[i].exp_total, $sformatf("vec%0d", i));
    end

    // Idle with no requests: nothing granted.
    req = '0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("idle gnt", gnt, 0);
      check("idle busy", busy, 0);
    end

    // Reset in the second RUN cycle drops the word and rewinds the pointer.
    reset_main();
    req = 4'b0001;
    dat_in[31:0] = 32'hFFFF0000;
    @(posedge clk); @(negedge clk);
    check("abort gnt", gnt, 4'b0001);
    req = '0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort async busy", busy, 0);
    check("abort async gnt", gnt, 0);
    check("abort async total", total, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      check("abort no done", done, 0);
    end
    req = 4'b1001;
    dat_in = {32'h00000007, 64'h0, 32'h0000000F};
    serve(0, 4, "after_abort");

    // Randomized traffic against a round-robin/popcount model.
    reset_main();
    mptr = 0;
    for (int it = 0; it < 40; it++) begin
      int r, w, mode;
      if ($urandom_range(0, 4) == 0) begin
        req = '0;
        @(posedge clk); @(negedge clk);
        check("rnd idle busy", busy, 0);
        continue;
      end
      r = $urandom_range(1, 15);
      for (int k = 0; k < 4; k++) begin
        mode = $urandom_range(0, 5);
        dat_in[k*32 +: 32] = (mode == 0) ? 32'hFFFFFFFF : (mode == 1) ? 32'h0 : $urandom;
      end
      w = -1;
      for (int k = 0; k < 4; k++) begin
        if (w < 0 && r[(mptr + k) % 4]) w = (mptr + k) % 4;
      end
      mptr = (w + 1) % 4;
      req = r[3:0];
      serve(w, $countones(dat_in[w*32 +: 32]), $sformatf("rnd%0d", it));
    end
    req = '0;

    // WORD_BYTES=1 build: one RUN cycle, back-to-back grants two cycles apart.
    @(negedge clk);
    rst1_n = 1'b1;
    req1 = 4'b0011;
    dat1 = {16'h0, 8'hFF, 8'hA5};
    @(posedge clk); @(negedge clk);
    check("wb1 gnt0", gnt1, 4'b0001);
    check("wb1 busy0", busy1, 1);
    req1[0] = 1'b0;
    dat1[7:0] = 8'h00;
    @(posedge clk); @(negedge clk);
    check("wb1 done0", done1, 1);
    check("wb1 id0", done_id1, 0);
    check("wb1 total0", total1, 4);
    $display("txn wb1_0: id=%0d total=%0d", done_id1, total1);
    @(posedge clk); @(negedge clk);
    check("wb1 gnt1", gnt1, 4'b0010);
    check("wb1 done_gap", done1, 0);
    req1[1] = 1'b0;
    @(posedge clk); @(negedge clk);
    check("wb1 done1", done1, 1);
    check("wb1 id1", done_id1, 1);
    check("wb1 total1", total1, 8);
    $display("txn wb1_1: id=%0d total=%0d", done_id1, total1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
